// File: rtl/riscv_pkg.sv
// Shared RV32I opcode constants, instruction format enum and opcode classification helpers.
package riscv_pkg;

   localparam logic [6:0] ALUTypeR   = 7'b0110011;
   localparam logic [6:0] ALUTypeI   = 7'b0010011;
   localparam logic [6:0] loadType   = 7'b0000011;
   localparam logic [6:0] storeType  = 7'b0100011;
   localparam logic [6:0] branchType = 7'b1100011;
   localparam logic [6:0] JALR       = 7'b1100111;
   localparam logic [6:0] LUI        = 7'b0110111;
   localparam logic [6:0] AUIPC      = 7'b0010111;
   localparam logic [6:0] JAL        = 7'b1101111;

   // addi x0, x0, 0
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

   // Unknown opcodes fall back to the R layout.
   function automatic fmt_e opcode_fmt(input logic [6:0] op);
      fmt_e fmt;
      case (op)
         ALUTypeI, loadType, JALR: fmt = FMT_I;
         storeType:                fmt = FMT_S;
         branchType:               fmt = FMT_B;
         LUI, AUIPC:               fmt = FMT_U;
         JAL:                      fmt = FMT_J;
         default:                  fmt = FMT_R;
      endcase
      return fmt;
   endfunction

   function automatic logic opcode_known(input logic [6:0] op);
      logic known;
      case (op)
         ALUTypeR, ALUTypeI, loadType, storeType, branchType,
         JALR, LUI, AUIPC, JAL: known = 1'b1;
         default:               known = 1'b0;
      endcase
      return known;
   endfunction

endpackage

// File: rtl/enc_fifo2.sv
// Two-entry synchronous FIFO; flags come straight from the registered count.
module enc_fifo2 #(
   parameter int unsigned Width = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [Width-1:0] rdata_o
);

   logic [Width-1:0] mem_q [2];
   logic             wptr_q, wptr_d;
   logic             rptr_q, rptr_d;
   logic [1:0]       count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == 2'd2);
   assign empty_o = (count_q == 2'd0);
   assign rdata_o = mem_q[rptr_q];

   always_comb begin
      do_push = push_i & ~full_o;
      do_pop  = pop_i & ~empty_o;
      wptr_d  = do_push ? ~wptr_q : wptr_q;
      rptr_d  = do_pop ? ~rptr_q : rptr_q;
      count_d = count_q;
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wptr_q   <= 1'b0;
         rptr_q   <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
         end
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/instr_encode.sv
// RV32I instruction encoder with 2-entry output buffer.
// Define IENC_CHECK_EN to replace illegal opcodes / R-type funct7 with a flagged NOP.
module instr_encode
   import riscv_pkg::*;
#(
   parameter int unsigned I_WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [6:0]         opcode_i,
   input  logic [4:0]         rd_i,
   input  logic [4:0]         rs1_i,
   input  logic [4:0]         rs2_i,
   input  logic [2:0]         f3_i,
   input  logic [6:0]         f7_i,
   input  logic [19:0]        imm_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [I_WIDTH-1:0] out_instr_o,
   output logic               out_err_o
);

   logic [I_WIDTH-1:0] enc;
   fmt_e               fmt;
   logic               full, empty;

   // B and J immediates arrive pre-shifted (bit 0 of the byte offset dropped).
   always_comb begin
      fmt = opcode_fmt(opcode_i);
      enc = {f7_i, rs2_i, rs1_i, f3_i, rd_i, opcode_i};
      case (fmt)
         FMT_I: enc = {imm_i[11:0], rs1_i, f3_i, rd_i, opcode_i};
         FMT_S: enc = {imm_i[11:5], rs2_i, rs1_i, f3_i, imm_i[4:0], opcode_i};
         FMT_B: enc = {imm_i[11], imm_i[9:4], rs2_i, rs1_i, f3_i, imm_i[3:0], imm_i[10],
                       opcode_i};
         FMT_U: enc = {imm_i[19:0], rd_i, opcode_i};
         FMT_J: enc = {imm_i[19], imm_i[9:0], imm_i[10], imm_i[18:11], rd_i, opcode_i};
         default: enc = {f7_i, rs2_i, rs1_i, f3_i, rd_i, opcode_i};
      endcase
   end

`ifdef IENC_CHECK_EN
   logic               illegal;
   logic [I_WIDTH:0]   wdata, rdata;

   always_comb begin
      illegal = ~opcode_known(opcode_i) |
                ((opcode_i == ALUTypeR) &
                 ~((f7_i == 7'h00) | (f7_i == 7'h20) | (f7_i == 7'h01)));
      wdata   = illegal ? {1'b1, NOP} : {1'b0, enc};
   end

   enc_fifo2 #(
      .Width(I_WIDTH + 1)
   ) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .push_i (in_valid_i),
      .wdata_i(wdata),
      .pop_i  (out_ready_i),
      .full_o (full),
      .empty_o(empty),
      .rdata_o(rdata)
   );

   assign out_instr_o = rdata[I_WIDTH-1:0];
   assign out_err_o   = rdata[I_WIDTH];
`else
   enc_fifo2 #(
      .Width(I_WIDTH)
   ) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .push_i (in_valid_i),
      .wdata_i(enc),
      .pop_i  (out_ready_i),
      .full_o (full),
      .empty_o(empty),
      .rdata_o(out_instr_o)
   );

   assign out_err_o = 1'b0;
`endif

   assign in_ready_o  = ~full;
   assign out_valid_o = ~empty;

endmodule

// File: tb/tb_instr_encode.sv
// Scoreboard bench for instr_encode: accepted field sets queue a reference encoding,
// a negedge monitor compares every popped word and the handshake flags.
module tb_instr_encode;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready, out_err;
   logic [6:0]  opcode, f7;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  f3;
   logic [19:0] imm;
   logic [31:0] out_instr;

   logic        dir_use;
   logic [32:0] dir_exp;
   logic [32:0] sb_q[$];
   int          n_checks = 0;
   int          n_errs = 0;

   always #5 clk = ~clk;

   instr_encode #(
      .I_WIDTH(32)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready),
      .opcode_i   (opcode),
      .rd_i       (rd),
      .rs1_i      (rs1),
      .rs2_i      (rs2),
      .f3_i       (f3),
      .f7_i       (f7),
      .imm_i      (imm),
      .out_valid_o(out_valid),
      .out_ready_i(out_ready),
      .out_instr_o(out_instr),
      .out_err_o  (out_err)
   );

   task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: standard RV32I packing from byte offsets, returns {err, word}.
   function automatic logic [32:0] model(input logic [6:0] op, input logic [4:0] d,
                                         input logic [4:0] s1, input logic [4:0] s2,
                                         input logic [2:0] fn3, input logic [6:0] fn7,
                                         input logic [19:0] im);
      longint unsigned lop, ld, ls1, ls2, lf3, lf7, lim, off, w;
      bit known;
      lop = op; ld = d; ls1 = s1; ls2 = s2; lf3 = fn3; lf7 = fn7; lim = im;
      known = 1;
      case (op)
         7'b0010011, 7'b0000011, 7'b1100111:
            w = ((lim & 64'hFFF) << 20) | (ls1 << 15) | (lf3 << 12) | (ld << 7) | lop;
         7'b0100011:
            w = (((lim >> 5) & 64'h7F) << 25) | (ls2 << 20) | (ls1 << 15) | (lf3 << 12) |
                ((lim & 64'h1F) << 7) | lop;
         7'b1100011: begin
            off = (lim & 64'hFFF) << 1;
            w = (((off >> 12) & 1) << 31) | (((off >> 5) & 64'h3F) << 25) | (ls2 << 20) |
                (ls1 << 15) | (lf3 << 12) | (((off >> 1) & 64'hF) << 8) |
                (((off >> 11) & 1) << 7) | lop;
         end
         7'b0110111, 7'b0010111:
            w = (lim << 12) | (ld << 7) | lop;
         7'b1101111: begin
            off = lim << 1;
            w = (((off >> 20) & 1) << 31) | (((off >> 1) & 64'h3FF) << 21) |
                (((off >> 11) & 1) << 20) | (((off >> 12) & 64'hFF) << 12) | (ld << 7) | lop;
         end
         default: begin
            known = (op == 7'b0110011);
            w = (lf7 << 25) | (ls2 << 20) | (ls1 << 15) | (lf3 << 12) | (ld << 7) | lop;
         end
      endcase
`ifdef IENC_CHECK_EN
      if (!known || (op == 7'b0110011 && !(fn7 == 7'h00 || fn7 == 7'h20 || fn7 == 7'h01)))
         return {1'b1, 32'h0000_0013};
`endif
      return {1'b0, w[31:0]};
   endfunction

   // Stimulus side: record the expected word for every accepted field set.
   always @(posedge clk) begin
      if (rst_n && in_valid && in_ready)
         sb_q.push_back(dir_use ? dir_exp : model(opcode, rd, rs1, rs2, f3, f7, imm));
   end

   // Monitor: flags against scoreboard occupancy, then compare the word popped next edge.
   always @(negedge clk) begin
      logic [32:0] e;
      if (rst_n) begin
         check("in_ready", in_ready, sb_q.size() < 2);
         check("out_valid", out_valid, sb_q.size() != 0);
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               check("unexpected_pop", 1'b1, 1'b0);
            end else begin
               e = sb_q.pop_front();
               check("out_instr", out_instr, e[31:0]);
               check("out_err", out_err, e[32]);
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after acceptance with in_valid still high.
   task automatic send(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [2:0] fn3, input logic [6:0] fn7,
                       input logic [19:0] im, input logic use_exp, input logic [32:0] exp);
      int guard;
      opcode = op; rd = d; rs1 = s1; rs2 = s2; f3 = fn3; f7 = fn7; imm = im;
      dir_use = use_exp; dir_exp = exp;
      in_valid = 1'b1;
      guard = 0;
      while (!in_ready && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 200) check("accept_timeout", 1'b1, 1'b0);
      @(posedge clk); #1;
   endtask

   task automatic drain();
      int guard;
      in_valid = 1'b0;
      dir_use = 1'b0;
      out_ready = 1'b1;
      guard = 0;
      while ((sb_q.size() != 0 || out_valid) && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      check("drain_timeout", guard >= 100, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0] ops [9];
      ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
              7'b1100111, 7'b0110111, 7'b0010111, 7'b1101111};
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; dir_use = 1'b0; dir_exp = '0;
      opcode = '0; rd = '0; rs1 = '0; rs2 = '0; f3 = '0; f7 = '0; imm = '0;
      #2;
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_instr", out_instr, 32'h0);
      check("rst_out_err", out_err, 1'b0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b1;

      send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 20'($urandom), 1'b1, 33'h0_002081B3);
      send(7'b0010011, 5'd1, 5'd0, 5'($urandom), 3'd0, 7'($urandom), 20'h00005, 1'b1,
           33'h0_00500093);
      send(7'b0110111, 5'd5, 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom),
           20'h12345, 1'b1, 33'h0_123452B7);
      send(7'b0100011, 5'($urandom), 5'd1, 5'd2, 3'd2, 7'($urandom), 20'h00008, 1'b1,
           33'h0_0020A423);
      send(7'b1100011, 5'($urandom), 5'd1, 5'd2, 3'd0, 7'($urandom), 20'h00004, 1'b1,
           33'h0_00208463);
      send(7'h7F, 5'd4, 5'd6, 5'd7, 3'd1, 7'h00, 20'h0, 1'b0, 33'h0);
      drain();

      // Backpressure: two accepts fill the buffer, the third waits for a pop.
      out_ready = 1'b0;
      fork
         begin
            send(7'b0110011, 5'd10, 5'd11, 5'd12, 3'd7, 7'h20, 20'h0, 1'b0, 33'h0);
            send(7'b0010011, 5'd13, 5'd14, 5'd0, 3'd4, 7'h0, 20'h0ABC, 1'b0, 33'h0);
            send(7'b1101111, 5'd15, 5'd0, 5'd0, 3'd0, 7'h0, 20'hF1234, 1'b0, 33'h0);
            in_valid = 1'b0;
         end
         begin
            repeat (2) @(posedge clk);
            #1 check("bp_in_ready_low", in_ready, 1'b0);
            check("bp_out_valid", out_valid, 1'b1);
            repeat (2) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();

      for (int i = 0; i < 400; i++) begin
         int idx;
         int k;
         idx = $urandom_range(0, 10);
         opcode = (idx < 9) ? ops[idx] : 7'($urandom);
         k = $urandom_range(0, 3);
         f7 = (k == 0) ? 7'h00 : (k == 1) ? 7'h20 : (k == 2) ? 7'h01 : 7'($urandom);
         rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
         f3 = 3'($urandom); imm = 20'($urandom);
         in_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end
      drain();

      // Reset with two buffered entries discards them at once.
      out_ready = 1'b0;
      send(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'h0, 20'h00111, 1'b0, 33'h0);
      send(7'b0010111, 5'd2, 5'd0, 5'd0, 3'd0, 7'h0, 20'h22222, 1'b0, 33'h0);
      in_valid = 1'b0;
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("rst2_out_valid", out_valid, 1'b0);
      check("rst2_in_ready", in_ready, 1'b1);
      check("rst2_out_instr", out_instr, 32'h0);
      sb_q.delete();
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(7'b0110011, 5'd9, 5'd8, 5'd7, 3'd5, 7'h01, 20'h0, 1'b1,
           {1'b0, 7'h01, 5'd7, 5'd8, 3'd5, 5'd9, 7'b0110011});
      drain();
      @(negedge clk);
      check("post_rst_empty", out_valid, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
